// File: rtl/rename_ctrl_pkg.sv
// Shared rename-control types: lane count, free-count width, control FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Lane count comes from the global MACHINE_WIDTH define.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 2
`endif

package rename_ctrl_pkg;
  localparam int MW  = `MACHINE_WIDTH;
  localparam int FCW = $clog2(MW + 1);
  // Recovery counter width; holds RECOV_CYCLES up to 15.
  localparam int RCW = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RECOVER = 2'd2
  } RENAME_CTRL_STATE;
endpackage

// File: rtl/rename_ctrl_if.sv
// Fetch-side and dispatch-side handshake bundle of the rename controller.
// Latency: n/a (wires only).
// Backpressure: rename_ready in, fetch_ready out; free_cnt limits PRN pops.
interface rename_ctrl_if;
  import rename_ctrl_pkg::*;

  logic [MW-1:0]  fetch_valid;
  logic [MW-1:0]  need_dest;
  logic [FCW-1:0] free_cnt;
  logic [MW-1:0]  rename_ready;
  logic [MW-1:0]  fetch_ready;
  logic [MW-1:0]  rename_valid;
  logic [MW-1:0]  prn_alloc;

  // Driven by fetch/decode, free list and dispatch models.
  modport master (
    output fetch_valid, need_dest, free_cnt, rename_ready,
    input  fetch_ready, rename_valid, prn_alloc
  );

  // The rename controller itself.
  modport slave (
    input  fetch_valid, need_dest, free_cnt, rename_ready,
    output fetch_ready, rename_valid, prn_alloc
  );
endinterface

// File: rtl/rename_lane_grant.sv
// In-order lane grant: a lane passes only if all lower lanes pass and PRNs suffice.
// Latency: purely combinational.
// Backpressure: a blocked lane (not ready or out of PRNs) blocks every higher lane.
module rename_lane_grant
  import rename_ctrl_pkg::*;
(
  input  logic [MW-1:0]  fetch_valid,
  input  logic [MW-1:0]  need_dest,
  input  logic [MW-1:0]  rename_ready,
  input  logic [FCW-1:0] free_cnt,
  output logic [MW-1:0]  grant
);

  logic [FCW-1:0] dest_sum;
  logic           chain;

  // Running destination count over lanes 0..i, and a chain that breaks at the first blocked lane.
  always_comb begin
    grant    = '0;
    dest_sum = '0;
    chain    = 1'b1;
    for (int i = 0; i < MW; i++) begin
      dest_sum = dest_sum + FCW'(need_dest[i]);
      chain    = chain & fetch_valid[i] & rename_ready[i] & (dest_sum <= free_cnt);
      grant[i] = chain;
    end
  end

endmodule

// File: rtl/rename_ctrl.sv
// Rename stage control: in-order lane grants, flush -> arch-state recovery sequencing.
// Latency: grants combinational; FLUSH 1 cycle then RECOV_CYCLES of recov_arch_st.
// Backpressure: all lanes closed while busy; optional perf counters via RENAME_CTRL_PERF_EN.
module rename_ctrl
  import rename_ctrl_pkg::*;
#(
  parameter int RECOV_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rename_ctrl_if.slave bus,
  input  logic         flush_req,
  output logic         recov_arch_st,
  output logic         rename_busy
`ifdef RENAME_CTRL_PERF_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [15:0]  flush_count
`endif
);

  localparam logic [RCW-1:0] RECOV_LOAD = RCW'(RECOV_CYCLES);

  RENAME_CTRL_STATE state_q, state_d;
  logic [RCW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]    grant;
  logic [MW-1:0]    valid_int;
  logic             run_open;

  rename_lane_grant u_grant (
    .fetch_valid  (bus.fetch_valid),
    .need_dest    (bus.need_dest),
    .rename_ready (bus.rename_ready),
    .free_cnt     (bus.free_cnt),
    .grant        (grant)
  );

  // State and recovery counter registers; recov_arch_st registered from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      recov_arch_st <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      recov_arch_st <= (state_d == RECOVER);
    end
  end

  // Next state / counter; lanes open only in RUN without a same-cycle flush.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    run_open = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else begin
          run_open = 1'b1;
        end
      end
      FLUSH: begin
        // A flush arriving here is redundant: recovery is about to start anyway.
        state_d = RECOVER;
        cnt_d   = RECOV_LOAD;
      end
      RECOVER: begin
        if (flush_req) begin
          cnt_d = RECOV_LOAD;
        end else if (cnt_q == RCW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - RCW'(1);
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Lane outputs are the grants gated by the open window.
  always_comb begin
    valid_int        = run_open ? grant : '0;
    bus.rename_valid = valid_int;
    bus.fetch_ready  = valid_int;
    bus.prn_alloc    = valid_int & bus.need_dest;
    rename_busy      = (state_q != RUN);
  end

`ifdef RENAME_CTRL_PERF_EN
  // Saturating counters: lane-0 stall cycles in RUN, and flushes acted upon (RUN or RECOVER).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((state_q == RUN) && bus.fetch_valid[0] && !valid_int[0] && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_req && (state_q != FLUSH) && (flush_count != '1)) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rename_ctrl.sv
// Self-checking bench for rename_ctrl: directed corner cases plus random traffic.
// Latency: reference model tracks flush/recovery phases as simple remaining-cycle counts.
// Backpressure: random rename_ready and free_cnt exercise in-order blocking.
module tb_rename_ctrl;
  import rename_ctrl_pkg::*;

  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_req;
  logic recov_arch_st;
  logic rename_busy;
`ifdef RENAME_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  rename_ctrl_if bus ();

  rename_ctrl #(.RECOV_CYCLES(RC)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .flush_req     (flush_req),
    .recov_arch_st (recov_arch_st),
    .rename_busy   (rename_busy)
`ifdef RENAME_CTRL_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: flush pending flag, recovery cycles remaining, perf tallies.
  bit m_flush;
  int m_recov;
  int m_stall;
  int m_fcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush = 1'b0;
    m_recov = 0;
    m_stall = 0;
    m_fcnt  = 0;
  endtask

  // Lanes are taken lowest first; stop at the first lane that is not valid, not ready,
  // or whose cumulative destination demand exceeds the free PRN count.
  function automatic logic [MW-1:0] ref_grant(input logic [MW-1:0] fv, input logic [MW-1:0] nd,
                                              input logic [MW-1:0] rr, input int fc);
    int need;
    ref_grant = '0;
    need = 0;
    for (int i = 0; i < MW; i++) begin
      need += int'(nd[i]);
      if (!(fv[i] && rr[i] && need <= fc)) break;
      ref_grant[i] = 1'b1;
    end
  endfunction

  task automatic drive(input logic [MW-1:0] fv, input logic [MW-1:0] nd, input int fc,
                       input logic [MW-1:0] rr, input logic fl);
    bus.fetch_valid  = fv;
    bus.need_dest    = nd;
    bus.free_cnt     = FCW'(fc);
    bus.rename_ready = rr;
    flush_req        = fl;
  endtask

  // One cycle: check all outputs at mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    logic [MW-1:0] eg;
    bit            open;
    @(negedge clk);
    #1;
    open = !m_flush && (m_recov == 0) && !flush_req;
    eg   = open ? ref_grant(bus.fetch_valid, bus.need_dest, bus.rename_ready, int'(bus.free_cnt)) : '0;
    check("rename_valid", 32'(bus.rename_valid), 32'(eg));
    check("fetch_ready", 32'(bus.fetch_ready), 32'(eg));
    check("prn_alloc", 32'(bus.prn_alloc), 32'(eg & bus.need_dest));
    check("recov_arch_st", 32'(recov_arch_st), 32'(m_recov > 0));
    check("rename_busy", 32'(rename_busy), 32'(m_flush || (m_recov > 0)));
`ifdef RENAME_CTRL_PERF_EN
    check("stall_cycles", stall_cycles, 32'(m_stall));
    check("flush_count", 32'(flush_count), 32'(m_fcnt));
`endif
    @(posedge clk);
    if (!m_flush && (m_recov == 0) && bus.fetch_valid[0] && !eg[0]) m_stall++;
    if (flush_req && !m_flush) m_fcnt++;
    if (m_flush) begin
      m_flush = 1'b0;
      m_recov = RC;
    end else if (m_recov > 0) begin
      m_recov = flush_req ? RC : m_recov - 1;
    end else if (flush_req) begin
      m_flush = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, 0, '0, 1'b0);
    model_reset();
    #12;
    check("reset_recov", 32'(recov_arch_st), 32'd0);
    check("reset_busy", 32'(rename_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single free PRN, both lanes want one: only lane 0 goes.
    drive(2'b11, 2'b11, 1, 2'b11, 1'b0);
    #1;
    check("free1_valid", 32'(bus.rename_valid), 32'h1);
    check("free1_alloc", 32'(bus.prn_alloc), 32'h1);
    step();

    // Lane 0 not ready blocks lane 1 even though lane 1 is ready.
    drive(2'b11, 2'b00, 0, 2'b10, 1'b0);
    #1;
    check("inorder_valid", 32'(bus.rename_valid), 32'h0);
    check("inorder_ready", 32'(bus.fetch_ready), 32'h0);
    step();

    // No PRNs: lane 0 without a destination still goes, lane 1 needing one does not.
    drive(2'b11, 2'b10, 0, 2'b11, 1'b0);
    #1;
    check("nodest_valid", 32'(bus.rename_valid), 32'h1);
    step();

    // Flush in RUN: closed same cycle, FLUSH, two RECOVER cycles, back to RUN.
    drive(2'b11, 2'b11, 2, 2'b11, 1'b1);
    #1;
    check("flush_t_valid", 32'(bus.rename_valid), 32'h0);
    step();
    flush_req = 1'b0;
    #1;
    check("flush_t1_busy", 32'(rename_busy), 32'd1);
    check("flush_t1_recov", 32'(recov_arch_st), 32'd0);
    step();
    check("flush_t2_recov", 32'(recov_arch_st), 32'd1);
    step();
    check("flush_t3_recov", 32'(recov_arch_st), 32'd1);
    step();
    check("flush_t4_busy", 32'(rename_busy), 32'd0);
    check("flush_t4_valid", 32'(bus.rename_valid), 32'h3);
    step();

    // Flush during the last RECOVER cycle restarts recovery.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    flush_req = 1'b1;
    #1;
    check("restart_recov", 32'(recov_arch_st), 32'd1);
    step();
    flush_req = 1'b0;
    #1;
    check("restart_r1", 32'(recov_arch_st), 32'd1);
    check("restart_busy1", 32'(rename_busy), 32'd1);
    step();
    check("restart_r2", 32'(recov_arch_st), 32'd1);
    step();
    check("restart_done", 32'(rename_busy), 32'd0);
    step();

    // Reset in the middle of recovery aborts it immediately.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_recov", 32'(recov_arch_st), 32'd0);
    check("arst_busy", 32'(rename_busy), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    drive(2'b11, 2'b11, 2, 2'b11, 1'b0);
    #1;
    check("post_rst_valid", 32'(bus.rename_valid), 32'h3);
    step();

`ifdef RENAME_CTRL_PERF_EN
    // Fresh counters, then five stalled cycles and one flush.
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
    drive(2'b11, 2'b11, 0, 2'b11, 1'b0);
    for (int i = 0; i < 5; i++) step();
    check("perf_stall5", stall_cycles, 32'd5);
    drive(2'b00, 2'b00, 2, 2'b11, 1'b1);
    step();
    flush_req = 1'b0;
    #1;
    check("perf_flush1", 32'(flush_count), 32'd1);
    for (int i = 0; i < 4; i++) step();
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      drive(MW'($urandom), MW'($urandom), int'($urandom_range(0, MW)),
            MW'($urandom), ($urandom_range(0, 9) == 0));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rename_ctrl.md
RENAME_CTRL -- requirements
Module: rename_ctrl

Interface
REQ-001 SHALL take parameter RECOV_CYCLES, default 2: number of cycles recov_arch_st is held high per recovery (legal range 1..15).
REQ-002 SHALL take lane count from the global `MACHINE_WIDTH define (MW below); FCW = $clog2(MW+1).
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_valid  input  MW  per-lane decoded packet valid.
REQ-006 SHALL have port need_dest  input  MW  lane writes a destination register and needs one free PRN.
REQ-007 SHALL have port free_cnt  input  FCW  free PRNs the free list can hand out this cycle.
REQ-008 SHALL have port rename_ready  input  MW  per-lane downstream accept.
REQ-009 SHALL have port flush_req  input  1  one-cycle pulse from retire on mispredict/exception.
REQ-010 SHALL have port fetch_ready  output  MW  per-lane accept toward fetch/decode.
REQ-011 SHALL have port rename_valid  output  MW  per-lane valid toward dispatch.
REQ-012 SHALL have port prn_alloc  output  MW  per-lane pop strobe to free list.
REQ-013 SHALL have port recov_arch_st  output  1  registered; RAT/free list/busy table restore from arch state.
REQ-014 SHALL have port rename_busy  output  1  high whenever state is not RUN.

Function
REQ-015 Lane grant g[i] SHALL be fetch_valid[i] & rename_ready[i] & (g[i-1] for i>0) & (dest prefix sum over lanes 0..i of need_dest <= free_cnt), all combinational.
REQ-016 Grants SHALL be strictly in order: no lane SHALL be granted while a lower lane is valid but not granted.
REQ-017 In RUN: rename_valid = fetch_ready = g; prn_alloc[i] = g[i] & need_dest[i]; popcount(prn_alloc) SHALL never exceed free_cnt.
REQ-018 States SHALL be RUN, FLUSH, RECOVER.
REQ-019 RUN -> FLUSH when flush_req=1; grants in that same cycle SHALL be forced to 0.
REQ-020 FLUSH lasts exactly one cycle, then RECOVER, loading recovery counter with RECOV_CYCLES.
REQ-021 RECOVER SHALL decrement the counter each cycle and return to RUN the cycle after the counter reaches 1.
REQ-022 recov_arch_st SHALL be high exactly during the RECOVER cycles (RECOV_CYCLES consecutive cycles).
REQ-023 In FLUSH and RECOVER: rename_valid, fetch_ready, prn_alloc SHALL be all-zero.
REQ-024 flush_req in FLUSH SHALL be ignored; flush_req in RECOVER SHALL reload the counter with RECOV_CYCLES (recovery restarts, recov_arch_st stays high).
REQ-025 free_cnt=0 with need_dest[0]=1 SHALL grant nothing; lanes without need_dest below the first blocked lane still grant.

Reset
REQ-026 rst_n low SHALL asynchronously force state RUN, counter 0, recov_arch_st 0, perf counters 0; combinational outputs follow from RUN.
REQ-027 Reset asserted mid-recovery SHALL abort it; first cycle after release is RUN with no recovery pending.

Configuration
REQ-028 Macro RENAME_CTRL_PERF_EN defined: adds outputs stall_cycles (32) and flush_count (16), saturating, counting RUN cycles with fetch_valid[0]&~g[0] and accepted flush_req respectively.
REQ-029 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold RENAME_CTRL_STATE enum (RUN/FLUSH/RECOVER) and uses existing MACHINE_WIDTH; no local copies.
REQ-031 One sub-module rename_lane_grant SHALL implement REQ-015 (prefix sum + in-order mask), purely combinational.

Verification
REQ-032 MW=2, fetch_valid=11, rename_ready=11, need_dest=11, free_cnt=1 -> rename_valid=01, prn_alloc=01.
REQ-033 fetch_valid=11, rename_ready=10 -> rename_valid=00, fetch_ready=00 (in-order block).
REQ-034 flush_req pulse at cycle t in RUN -> outputs zero at t, FLUSH at t+1, recov_arch_st high t+2..t+3 (RECOV_CYCLES=2), RUN at t+4.
REQ-035 flush_req again at second RECOVER cycle -> recov_arch_st stays high two further cycles, rename_busy continuous.
REQ-036 rst_n low during RECOVER -> recov_arch_st 0 immediately (async); after release fetch_valid=11, free_cnt=2 -> rename_valid=11.
REQ-037 With RENAME_CTRL_PERF_EN, 5 blocked cycles (free_cnt=0, need_dest[0]=1) -> stall_cycles=5; one flush -> flush_count=1.
